// File: rtl/act_buf_pkg.sv
// Shared types and constants for the activation skew buffer.
//   state_e   : burst FSM encoding (idle, issuing reads, final output cycle)
//   NUM_BANKS : ping-pong banks per lane
//   BANK_W    : width of a bank index
package act_buf_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned BANK_W    = 1;

endpackage

// File: rtl/act_skew_buffer_if.sv
// Loader / controller / array-side signal bundle of the activation skew buffer.
//   slave  : buffer side (loader writes, burst command in; status and lane data out)
//   master : driver side (loader, controller, array)
interface act_skew_buffer_if #(
  parameter int unsigned ARRAY_N    = 8,
  parameter int unsigned ACT_WIDTH  = 8,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int unsigned ROWS_WIDTH = $clog2(ARRAY_N) + 1
);

  logic [ARRAY_N-1:0]           w_en;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic [ACT_WIDTH-1:0]         w_data;
  logic                         w_fill_done;
  logic                         w_ready;
  logic                         start;
  logic                         skew_en;
  logic [ADDR_WIDTH-1:0]        base_addr;
  logic [LEN_WIDTH-1:0]         length;
  logic [ROWS_WIDTH-1:0]        num_rows;
  logic                         rd_ready;
  logic                         busy;
  logic                         done;
  logic [ARRAY_N-1:0]           act_valid;
  logic [ARRAY_N*ACT_WIDTH-1:0] act_data_out;

  modport slave (
    input  w_en, w_addr, w_data, w_fill_done, start, skew_en, base_addr, length, num_rows,
    output w_ready, rd_ready, busy, done, act_valid, act_data_out
  );

  modport master (
    output w_en, w_addr, w_data, w_fill_done, start, skew_en, base_addr, length, num_rows,
    input  w_ready, rd_ready, busy, done, act_valid, act_data_out
  );

endinterface

// File: rtl/act_skew_addr_gen.sv
// Burst cycle counter and per-lane read issue generation.
//   start_i     : burst accepted this cycle (counter restarts at 0 next cycle)
//   run_i       : FSM is issuing reads
//   skew_en_i   : lane n delayed by n cycles when set
//   base_addr_i, length_i, num_rows_i : latched burst parameters (num_rows already clamped)
//   issue_o     : per-lane read strobe
//   addr_o      : per-lane in-bank read address (wraps modulo bank depth)
//   last_o      : final issue cycle of the burst
module act_skew_addr_gen #(
  parameter int unsigned ARRAY_N    = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned ROWS_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start_i,
  input  logic                                 run_i,
  input  logic                                 skew_en_i,
  input  logic [ADDR_WIDTH-1:0]                base_addr_i,
  input  logic [LEN_WIDTH-1:0]                 length_i,
  input  logic [ROWS_WIDTH-1:0]                num_rows_i,
  output logic [ARRAY_N-1:0]                   issue_o,
  output logic [ARRAY_N-1:0][ADDR_WIDTH-1:0]   addr_o,
  output logic                                 last_o
);

  // Wide enough for length plus the largest lane delay.
  localparam int unsigned CNT_WIDTH = LEN_WIDTH + ROWS_WIDTH;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_ext, skew_max;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign len_ext  = CNT_WIDTH'(length_i);
  assign skew_max = skew_en_i ? (CNT_WIDTH'(num_rows_i) - CNT_WIDTH'(1)) : '0;
  // Last lane's window closes at length + skew_max - 1.
  assign last_o   = run_i && (cnt_q == len_ext + skew_max - CNT_WIDTH'(1));

  for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
    logic [CNT_WIDTH-1:0] delay;
    assign delay      = skew_en_i ? CNT_WIDTH'(n) : '0;
    assign issue_o[n] = run_i && (ROWS_WIDTH'(n) < num_rows_i) &&
                        (cnt_q >= delay) && (cnt_q < delay + len_ext);
    assign addr_o[n]  = base_addr_i + ADDR_WIDTH'(cnt_q - delay);
  end

endmodule

// File: rtl/act_skew_buffer.sv
// Ping-pong activation buffer feeding the systolic array rows. The loader fills the write bank of
// every lane while the array drains the read bank as a skewed or aligned burst.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : loader write port, burst command/status and per-lane output data
module act_skew_buffer
  import act_buf_pkg::*;
#(
  parameter int unsigned ARRAY_N    = 8,
  parameter int unsigned ACT_WIDTH  = 8,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  act_skew_buffer_if.slave bus
);

  localparam int unsigned ROWS_WIDTH = $clog2(ARRAY_N) + 1;

  state_e                 state_q, state_d;
  logic [BANK_W-1:0]      wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [NUM_BANKS-1:0]   full_q, full_d;
  logic                   skew_q, skew_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [ROWS_WIDTH-1:0]  rows_q, rows_d;
  logic [ARRAY_N-1:0]     valid_q, valid_d;

  logic                   w_ready, rd_ready, start_ok, fill_ok, last_issue;
  logic [ROWS_WIDTH-1:0]  rows_clamped;
  logic [ARRAY_N-1:0]     issue;
  logic [ARRAY_N-1:0][ADDR_WIDTH-1:0] rd_addr;

  assign w_ready      = ~full_q[wr_bank_q];
  assign rd_ready     = (state_q == StIdle) && full_q[rd_bank_q];
  assign rows_clamped = (bus.num_rows > ROWS_WIDTH'(ARRAY_N)) ? ROWS_WIDTH'(ARRAY_N)
                                                              : bus.num_rows;
  assign start_ok     = bus.start && rd_ready && (bus.num_rows != '0) && (bus.length != '0);
  assign fill_ok      = bus.w_fill_done && w_ready;

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    skew_d    = skew_q;
    base_d    = base_q;
    len_d     = len_q;
    rows_d    = rows_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
          skew_d  = bus.skew_en;
          base_d  = bus.base_addr;
          len_d   = bus.length;
          rows_d  = rows_clamped;
        end
      end
      StRun: begin
        if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        // Final output cycle: release the drained bank.
        state_d           = StIdle;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = rd_bank_q + BANK_W'(1);
      end
      default: state_d = StIdle;
    endcase
    // A full write bank is never the active read bank, so this never collides with the release.
    if (fill_ok) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = wr_bank_q + BANK_W'(1);
    end
  end

  assign valid_d = issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      full_q    <= '0;
      skew_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      rows_q    <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      skew_q    <= skew_d;
      base_q    <= base_d;
      len_q     <= len_d;
      rows_q    <= rows_d;
      valid_q   <= valid_d;
    end
  end

  act_skew_addr_gen #(
    .ARRAY_N    (ARRAY_N),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .ROWS_WIDTH (ROWS_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_ok),
    .run_i       (state_q == StRun),
    .skew_en_i   (skew_q),
    .base_addr_i (base_q),
    .length_i    (len_q),
    .num_rows_i  (rows_q),
    .issue_o     (issue),
    .addr_o      (rd_addr),
    .last_o      (last_issue)
  );

  for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
    // Both banks of a lane share one array; the bank index is the top address bit.
    logic [ACT_WIDTH-1:0] mem [2*DEPTH];
    logic [ACT_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (issue[n]) rd_data_d = mem[{rd_bank_q, rd_addr[n]}];
    end

    always_ff @(posedge clk) begin
      if (bus.w_en[n] && w_ready) mem[{wr_bank_q, bus.w_addr}] <= bus.w_data;
      rd_data_q <= rd_data_d;
    end

    // Masking with the valid flag also zeroes the lane immediately on reset.
    assign bus.act_data_out[n*ACT_WIDTH +: ACT_WIDTH] = valid_q[n] ? rd_data_q : '0;
  end

  assign bus.w_ready   = w_ready;
  assign bus.rd_ready  = rd_ready;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDrain);
  assign bus.act_valid = valid_q;

endmodule

// File: tb/tb_act_skew_buffer.sv
module tb_act_skew_buffer;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  act_skew_buffer_if #(.ARRAY_N(N), .ACT_WIDTH(W), .DEPTH(DEPTH)) bus ();

  act_skew_buffer #(.ARRAY_N(N), .ACT_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit [7:0] mem_m [N][2][DEPTH];
  int       m_wr, m_rd;
  bit [1:0] m_full;
  bit       m_act;
  longint   cyc, m_acc;
  int       m_len, m_rows, m_skew, m_base, m_bank;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 2'b00; m_act = 1'b0; m_acc = 0;
    m_len = 0; m_rows = 0; m_skew = 0; m_base = 0; m_bank = 0;
  endtask

  // Expected outputs during the current cycle, derived from burst timing rules.
  task automatic model_expect(output logic [N-1:0] v, output logic [N*W-1:0] d,
                              output logic dn, output logic bz, output logic wr,
                              output logic rr);
    longint r;
    longint k;
    r  = cyc - m_acc;
    v  = '0;
    d  = '0;
    bz = m_act;
    dn = m_act && (r == longint'(1 + m_len + (m_skew != 0 ? m_rows - 1 : 0)));
    for (int n = 0; n < int'(N); n++) begin
      k = r - 2 - (m_skew != 0 ? n : 0);
      if (m_act && n < m_rows && k >= 0 && k < m_len) begin
        v[n]       = 1'b1;
        d[n*W +: W] = mem_m[n][m_bank][int'((m_base + k) % DEPTH)];
      end
    end
    wr = !m_full[m_wr];
    rr = !m_act && m_full[m_rd];
  endtask

  task automatic model_step();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic           dn, bz, wr, rr;
    model_expect(v, d, dn, bz, wr, rr);
    if (wr) begin
      for (int n = 0; n < int'(N); n++)
        if (bus.w_en[n]) mem_m[n][m_wr][bus.w_addr] = bus.w_data;
    end
    if (rr && bus.start && bus.num_rows != 0 && bus.length != 0) begin
      m_act  = 1'b1;
      m_acc  = cyc;
      m_len  = int'(bus.length);
      m_rows = (bus.num_rows > N) ? N : int'(bus.num_rows);
      m_skew = int'(bus.skew_en);
      m_base = int'(bus.base_addr);
      m_bank = m_rd;
    end
    if (dn) begin
      m_full[m_rd] = 1'b0;
      m_rd         = m_rd ^ 1;
      m_act        = 1'b0;
    end
    if (bus.w_fill_done && wr) begin
      m_full[m_wr] = 1'b1;
      m_wr         = m_wr ^ 1;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial begin
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic           dn, bz, wr, rr;
    forever begin
      @(negedge clk);
      model_expect(v, d, dn, bz, wr, rr);
      chk("act_valid", bus.act_valid, v);
      chk("act_data", bus.act_data_out, d);
      chk("done", bus.done, dn);
      chk("busy", bus.busy, bz);
      chk("w_ready", bus.w_ready, wr);
      chk("rd_ready", bus.rd_ready, rr);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] lane(input int n);
    return bus.act_data_out[n*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.w_en        = '0;
    bus.w_fill_done = 1'b0;
    bus.start       = 1'b0;
  endtask

  task automatic hand_over();
    bus.w_fill_done = 1'b1;
    step();
    bus.w_fill_done = 1'b0;
  endtask

  // Lane n, address a holds tag + 16*n + a.
  task automatic fill(input logic [7:0] tag);
    for (int n = 0; n < int'(N); n++) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        bus.w_en   = N'(1 << n);
        bus.w_addr = 4'(a);
        bus.w_data = tag + 8'(16 * n + a);
        step();
      end
    end
    bus.w_en = '0;
    hand_over();
  endtask

  // Presents start for one cycle; returns in cycle 1 of the (possible) burst.
  task automatic burst_start(input int base, input int len, input int rows, input bit skew);
    bus.start     = 1'b1;
    bus.base_addr = 4'(base);
    bus.length    = 5'(len);
    bus.num_rows  = 3'(rows);
    bus.skew_en   = skew;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_in();
    bus.w_addr = '0; bus.w_data = '0; bus.skew_en = 1'b0;
    bus.base_addr = '0; bus.length = '0; bus.num_rows = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset in the middle of a burst.
    fill(8'h00);
    burst_start(0, 8, 4, 1'b1);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.act_valid, 0);
    chk("rst_data", bus.act_data_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_w_ready", bus.w_ready, 1);
    chk("rst_rd_ready", bus.rd_ready, 0);
    repeat (3) step();
    reset = 1'b1;

    // Skewed burst over bank0 contents kept across reset.
    hand_over();
    burst_start(0, 3, 4, 1'b1);
    for (int r = 1; r <= 8; r++) begin
      if (r == 4) begin chk("t2_l2_c4", lane(2), 8'h20); chk("t2_v2_c4", bus.act_valid[2], 1); end
      if (r == 5) chk("t2_l2_c5", lane(2), 8'h21);
      if (r == 6) begin chk("t2_l2_c6", lane(2), 8'h22); chk("t2_done_c6", bus.done, 0); end
      if (r == 7) begin chk("t2_done_c7", bus.done, 1); chk("t2_l3_c7", lane(3), 8'h32); end
      if (r == 8) begin chk("t2_busy_c8", bus.busy, 0); chk("t2_rdy_c8", bus.rd_ready, 0); end
      step();
    end

    // Aligned burst on two rows (same data pattern in bank1).
    fill(8'h00);
    burst_start(0, 3, 2, 1'b0);
    for (int r = 1; r <= 5; r++) begin
      if (r == 2) begin chk("t3_v_c2", bus.act_valid, 4'b0011); chk("t3_l1_c2", lane(1), 8'h10); end
      if (r == 4) begin
        chk("t3_done_c4", bus.done, 1);
        chk("t3_l1_c4", lane(1), 8'h12);
        chk("t3_v_c4", bus.act_valid, 4'b0011);
      end
      if (r == 5) begin chk("t3_v_c5", bus.act_valid, 0); chk("t3_busy_c5", bus.busy, 0); end
      step();
    end

    // Wrapping burst on bank0 while bank1 is refilled; fill_done coincides with done.
    fill(8'h00);
    burst_start(14, 4, 4, 1'b1);
    for (int r = 1; r <= 9; r++) begin
      if (r == 2) chk("t4_l0_c2", lane(0), 8'h0E);
      if (r == 3) chk("t4_l0_c3", lane(0), 8'h0F);
      if (r == 4) chk("t4_l0_c4", lane(0), 8'h00);
      if (r == 5) chk("t4_l0_c5", lane(0), 8'h01);
      if (r == 8) begin chk("t4_done_c8", bus.done, 1); chk("t4_l3_c8", lane(3), 8'h31); end
      if (r == 9) begin
        chk("t5_rdy_c9", bus.rd_ready, 1);
        chk("t5_wrdy_c9", bus.w_ready, 1);
        chk("t5_busy_c9", bus.busy, 0);
      end
      bus.w_en        = (r <= 4) ? 4'hF : 4'h0;
      bus.w_addr      = 4'(r - 1);
      bus.w_data      = 8'h80 + 8'(r - 1);
      bus.w_fill_done = (r == 8);
      if (r == 9) begin
        bus.start = 1'b1; bus.base_addr = '0; bus.length = 5'd4;
        bus.num_rows = 3'd4; bus.skew_en = 1'b0;
      end
      step();
    end
    idle_in();
    for (int r = 1; r <= 6; r++) begin
      if (r == 2) begin chk("t5_l0_c2", lane(0), 8'h80); chk("t5_l1_c2", lane(1), 8'h80); end
      if (r == 3) chk("t5_l2_c3", lane(2), 8'h81);
      if (r == 5) begin chk("t5_done_c5", bus.done, 1); chk("t5_l3_c5", lane(3), 8'h83); end
      if (r == 6) chk("t5_busy_c6", bus.busy, 0);
      step();
    end

    // Ignored starts and dropped writes.
    burst_start(0, 1, 1, 1'b0);
    chk("t6_norrdy_busy", bus.busy, 0);
    hand_over();
    hand_over();
    chk("t6_wrdy_full", bus.w_ready, 0);
    chk("t6_rrdy_full", bus.rd_ready, 1);
    bus.w_en = 4'b0001; bus.w_addr = 4'd5; bus.w_data = 8'hEE;
    step();
    bus.w_en = '0;
    burst_start(0, 0, 1, 1'b0);
    chk("t6_len0_busy", bus.busy, 0);
    burst_start(0, 1, 0, 1'b0);
    chk("t6_rows0_busy", bus.busy, 0);
    burst_start(5, 1, 1, 1'b0);
    step();
    chk("t6_l0_c2", lane(0), 8'h05);
    chk("t6_v_c2", bus.act_valid, 4'b0001);
    chk("t6_done_c2", bus.done, 1);
    step();
    chk("t6_busy_c3", bus.busy, 0);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.w_en        = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bus.w_addr      = 4'($urandom_range(0, DEPTH - 1));
      bus.w_data      = 8'($urandom_range(0, 255));
      bus.w_fill_done = ($urandom_range(0, 7) == 0);
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.skew_en     = 1'($urandom_range(0, 1));
      bus.base_addr   = 4'($urandom_range(0, DEPTH - 1));
      bus.length      = 5'($urandom_range(0, DEPTH));
      bus.num_rows    = 3'($urandom_range(0, 7));
      step();
    end
    idle_in();
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
